bit_matrix_permuter: RTL
========================

Name: bit_matrix_permuter

Overview:
- Parametrised successor to the fixed 8x8 read/count/map/convert/write chain.
- Takes an N x N bit matrix and produces its image under a run-time-selected coordinate mapping: identity, transpose, rotate-90-clockwise or rotate-180.
- One source bit is relocated per clock, driven by an internal (i,j) walker, under a start/busy/done handshake.
- Sits between the matrix reader and the file-writing memory handler.

Parameters:
- N, 8, matrix dimension (rows = cols), legal range 2..16.
- IW, $clog2(N), width of the row/column coordinate.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new permutation; sampled only in IDLE.
- mode  in  2  mapping select; latched on an accepted start.
- abort  in  1  cancel an in-progress walk.
- in_matrix  in  N*N  source matrix; bit (i*N+j) holds element (row i, col j); latched on an accepted start.
- out_matrix  out  N*N  result register, same bit ordering as in_matrix.
- busy  out  1  high while walking.
- done  out  1  one-cycle pulse; out_matrix is complete while done is high.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; out_matrix=0; busy=0; done=0.
  - Latched source, mode, i and j all cleared to 0.
- Bit ordering: element (r,c) lives at bit index r*N+c. Bit 0 is (0,0); bit N*N-1 is (N-1,N-1).
- Mode mapping of source (i,j) to destination (ni,nj):
  - 0 identity: (i, j).
  - 1 transpose: (j, i).
  - 2 rot90cw: (j, N-1-i).
  - 3 rot180: (N-1-i, N-1-j).
- States: IDLE, WALK, DONE.
- IDLE:
  - On start=1 at edge k: latch in_matrix and mode, clear out_matrix to 0, set i=j=0, busy=1, go to WALK.
  - With start=0: hold; out_matrix keeps its last result.
- WALK:
  - Each edge: out_matrix[ni*N+nj] <= src[i*N+j].
  - Advance j; when j==N-1, set j=0 and increment i.
  - The write for (N-1,N-1) happens at edge k+N*N. On that edge: busy=0, done=1, go to DONE.
  - start, mode and in_matrix changes are ignored during WALK.
- DONE: the next edge sets done=0 and goes to IDLE. A start seen on this edge is ignored; start must be re-asserted in IDLE.
- Latency: N*N edges from the start-sampling edge to done high (64 for N=8).
- Throughput: a new start is accepted no earlier than 2 edges after done rises.
- abort=1 in WALK:
  - Next edge goes to IDLE with busy=0 and done=0.
  - out_matrix keeps its partial contents.
  - abort has priority over the final-write transition.
  - abort is ignored in IDLE and DONE.
- Mapping is a bijection for every mode, so each destination bit is written exactly once per run.
- Coordinate arithmetic is IW bits wide. N-1-i never underflows because i < N.
- rst asserted mid-walk: immediate return to the reset values; no done pulse is issued.

Decomposition:
- Shared package matrix_pkg holds:
  - Mode constants: MODE_ID=2'd0, MODE_TR=2'd1, MODE_R90=2'd2, MODE_R180=2'd3.
  - The state encoding: IDLE, WALK, DONE.
  - The default N=8.
- One combinational sub-module, coord_mapper (parameter N), with:
  - Inputs: i, j, mode.
  - Output: destination bit index ni*N+nj.
- Walker, FSM and registers stay in bit_matrix_permuter.

Test Plan:
- N=8, mode=1, in=64'h0000_0000_0000_0002 -> done high exactly 64 edges after the start edge; out=64'h0000_0000_0000_0100.
- N=8, mode=2, in=64'h0000_0000_0000_0002 -> out=64'h0000_0000_0000_8000. Second run, in=64'h0000_0000_0000_0001 -> out=64'h0000_0000_0000_0080.
- N=8, mode=3, in=64'h0000_0000_0000_0002 -> out=64'h4000_0000_0000_0000. mode=0, in=64'hDEAD_BEEF_0123_4567 -> out identical.
- N=8, start held high continuously -> busy/done sequence repeats with period 66 edges. in_matrix changed mid-walk does not affect that run's result.
- abort pulsed 10 edges into a mode=1 run, in=64'hFFFF_FFFF_FFFF_FFFF -> IDLE next edge, done never pulses, busy=0. A subsequent start clears out_matrix before walking.
- N=3, mode=2, in=9'b000000001 -> out=9'b000000100 after 9 edges. rst driven low mid-walk -> out_matrix=0 and busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants for the bit-matrix permuter: mapping modes,
// FSM state encoding and the default matrix dimension.
package matrix_pkg;

    localparam int N_DEF = 8;

    localparam logic [1:0] MODE_ID   = 2'd0;
    localparam logic [1:0] MODE_TR   = 2'd1;
    localparam logic [1:0] MODE_R90  = 2'd2;
    localparam logic [1:0] MODE_R180 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bit_matrix_permuter_if.sv
// Request/result bundle of the permuter. master: requester (start, mode,
// abort, in_matrix); slave: permuter (out_matrix, busy, done).
interface bit_matrix_permuter_if
    import matrix_pkg::*;
#(
    parameter int N = N_DEF
);

    logic             start;
    logic [1:0]       mode;
    logic             abort;
    logic [N*N-1:0]   in_matrix;
    logic [N*N-1:0]   out_matrix;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output mode,
        output abort,
        output in_matrix,
        input  out_matrix,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  mode,
        input  abort,
        input  in_matrix,
        output out_matrix,
        output busy,
        output done
    );

endinterface

// File: rtl/coord_mapper.sv
// Maps a source coordinate (i,j) to the destination bit index ni*N+nj.
// Ports: i, j (row/col), mode (mapping select), idx (destination bit).
module coord_mapper
    import matrix_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [$clog2(N)-1:0]   i,
    input  logic [$clog2(N)-1:0]   j,
    input  logic [1:0]             mode,
    output logic [$clog2(N*N)-1:0] idx
);

    localparam int IW = $clog2(N);
    localparam int XW = $clog2(N*N);
    localparam logic [IW-1:0] LAST = IW'(N-1);
    localparam logic [XW-1:0] NW   = XW'(N);

    logic [IW-1:0] ni;
    logic [IW-1:0] nj;

    always_comb begin
        ni = i;
        nj = j;
        unique case (mode)
            MODE_ID: begin
                ni = i;
                nj = j;
            end
            MODE_TR: begin
                ni = j;
                nj = i;
            end
            MODE_R90: begin
                ni = j;
                nj = LAST - i;
            end
            MODE_R180: begin
                ni = LAST - i;
                nj = LAST - j;
            end
        endcase
    end

    assign idx = XW'(ni) * NW + XW'(nj);

endmodule

// File: rtl/bit_matrix_permuter.sv
// Relocates one bit per clock from a latched N x N source into out_matrix.
// Ports: clk, rst (async active-low), bus (slave side of the request bundle).
module bit_matrix_permuter
    import matrix_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    bit_matrix_permuter_if.slave  bus
);

    localparam int NN = N * N;
    localparam int XW = $clog2(N*N);
    localparam logic [IW-1:0] LAST = IW'(N-1);
    localparam logic [XW-1:0] NW   = XW'(N);

    state_e         state_q, state_d;
    logic [NN-1:0]  src_q, src_d;
    logic [NN-1:0]  out_q, out_d;
    logic [1:0]     mode_q, mode_d;
    logic [IW-1:0]  i_q, i_d;
    logic [IW-1:0]  j_q, j_d;

    logic [XW-1:0]  src_idx;
    logic [XW-1:0]  dst_idx;
    logic           last;

    assign src_idx = XW'(i_q) * NW + XW'(j_q);
    assign last    = (i_q == LAST) && (j_q == LAST);

    coord_mapper #(.N(N)) u_map (
        .i    (i_q),
        .j    (j_q),
        .mode (mode_q),
        .idx  (dst_idx)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        out_d   = out_q;
        mode_d  = mode_q;
        i_d     = i_q;
        j_d     = j_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d   = bus.in_matrix;
                    mode_d  = bus.mode;
                    out_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = WALK;
                end
            end
            WALK: begin
                // abort wins over the final write; the aborted edge writes nothing
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    out_d[dst_idx] = src_q[src_idx];
                    if (last) begin
                        i_d     = '0;
                        j_d     = '0;
                        state_d = DONE;
                    end else if (j_q == LAST) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            out_q   <= '0;
            mode_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign bus.out_matrix = out_q;
    assign bus.busy       = (state_q == WALK);
    assign bus.done       = (state_q == DONE);

endmodule
